// File: rtl/common_pkg.sv
// Common bus and word types shared across the pipeline.
package common_pkg;

   typedef logic [63:0] word_t;
   typedef logic [31:0] u32;

   // Instruction bus request: one outstanding transfer at a time.
   typedef struct packed {
      logic  valid;
      word_t addr;
   } ibus_req_t;

   // Instruction bus response: data_ok ends the transfer, addr_ok is informational.
   typedef struct packed {
      logic addr_ok;
      logic data_ok;
      u32   data;
   } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types for the fetch stage and the F/D register.
// Optional build macro: FETCH_MISALIGN_EXC_EN adds a misalign flag to fetch_data_t.
package pipes_pkg;

   import common_pkg::*;

   localparam word_t PC_RESET_DEFAULT = 64'h8000_0000;
   localparam int    PC_STEP_DEFAULT  = 4;
   localparam u32    NOP_INSTR        = 32'h0000_0013;

   typedef struct packed {
      word_t pc;
      u32    raw_instr;
   } fetch_instr_t;

   typedef struct packed {
      logic         valid;
      fetch_instr_t instr;
`ifdef FETCH_MISALIGN_EXC_EN
      logic         misalign;
`endif
   } fetch_data_t;

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DISCARD
   } fetch_state_t;

   // Build a valid F/D entry; any extra flags start cleared.
   function automatic fetch_data_t pack_entry(input word_t pc, input u32 raw);
      fetch_data_t e;
      e                 = '0;
      e.valid           = 1'b1;
      e.instr.pc        = pc;
      e.instr.raw_instr = raw;
      return e;
   endfunction

endpackage

// File: rtl/pcselect.sv
// Next-PC selection: redirect target beats sequential advance beats hold.
module pcselect
   import common_pkg::*;
#(
   parameter int PC_STEP = 4
) (
   input  word_t pc,
   input  logic  advance,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   output word_t next_pc
);

   // Priority mux for the next PC value (wraps modulo 2^64).
   always_comb begin
      // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
      next_pc = pc;
      if (redirect_valid) begin
         next_pc = redirect_pc;
      end else if (advance) begin
         next_pc = pc + word_t'(PC_STEP);
      end
   end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus and the
// F/D register, absorbs decode stalls and discards responses made stale by
// an execute redirect.
// Optional build macro: FETCH_MISALIGN_EXC_EN (misaligned PC raises an
// exception entry instead of a bus request).
module fetch
   import common_pkg::*, pipes_pkg::*;
#(
   parameter word_t PC_RESET = PC_RESET_DEFAULT,
   parameter int    PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        stall,
   input  logic        redirect_valid,
   input  word_t       redirect_pc,
   output fetch_data_t dataF
);

   fetch_state_t state;
   word_t        pc;
   word_t        next_pc;
   word_t        stale_addr;   // address of the in-flight request being discarded
   u32           hold_data;    // response parked while decode stalls; its pc is still in pc
   logic         fetch_req;    // FETCH with a bus request actually issued
   logic         advance;
   logic         unused_addr_ok;

`ifdef FETCH_MISALIGN_EXC_EN
   logic exc_sent;             // exception entry already delivered for this misaligned pc
   assign fetch_req = (state == FETCH) && (pc[1:0] == 2'b00);
`else
   assign fetch_req = (state == FETCH);
`endif

   assign unused_addr_ok = iresp.addr_ok;

   // Sequential step when decode takes a fresh instruction (bus data or the parked one).
   assign advance = !stall && ((fetch_req && iresp.data_ok) || (state == HOLD));

   pcselect #(
      .PC_STEP(PC_STEP)
   ) u_pcselect (
      .pc            (pc),
      .advance       (advance),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .next_pc       (next_pc)
   );

   // Bus request: live in FETCH and DISCARD; DISCARD keeps the stale address stable.
   always_comb begin
      ireq.valid = fetch_req || (state == DISCARD);
      ireq.addr  = (state == DISCARD) ? stale_addr : pc;
   end

   // State machine, PC register and F/D register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         pc         <= PC_RESET;
         stale_addr <= '0;
         hold_data  <= '0;
         dataF      <= '0;
`ifdef FETCH_MISALIGN_EXC_EN
         exc_sent   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pc <= next_pc;
         if (redirect_valid) begin
            // Redirect wins over stall and data: flush F/D and drop the parked entry.
            dataF.valid <= 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
            exc_sent    <= 1'b0;
`endif
            if (state == HOLD) begin
               state <= FETCH;
            end else if (fetch_req && !iresp.data_ok) begin
               stale_addr <= pc;
               state      <= DISCARD;
            end
         end else begin
            case (state)
               FETCH: begin
                  if (fetch_req) begin
                     if (iresp.data_ok && !stall) begin
                        dataF <= pack_entry(pc, iresp.data);
                     end else if (iresp.data_ok) begin
                        hold_data <= iresp.data;
                        state     <= HOLD;
                     end else if (!stall) begin
                        dataF.valid <= 1'b0;
                     end
                  end
`ifdef FETCH_MISALIGN_EXC_EN
                  else if (!stall) begin
                     if (!exc_sent) begin
                        dataF          <= pack_entry(pc, NOP_INSTR);
                        dataF.misalign <= 1'b1;
                        exc_sent       <= 1'b1;
                     end else begin
                        dataF.valid <= 1'b0;
                     end
                  end
`endif
               end
               HOLD: begin
                  if (!stall) begin
                     dataF <= pack_entry(pc, hold_data);
                     state <= FETCH;
                  end
               end
               DISCARD: begin
                  dataF.valid <= 1'b0;
                  if (iresp.data_ok) begin
                     state <= FETCH;
                  end
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

endmodule
